l2_cacheline_adaptor: RTL and testbench

L2_CACHELINE_ADAPTOR -- requirements
Module: l2_cacheline_adaptor

---
 rtl/l2_cacheline_adaptor.sv | 93 +++++++++
 tb/tb_l2_cacheline_adaptor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adaptor.sv
// Bridges L2 line-sized fill/writeback requests onto a narrower burst memory
// port, serialising or assembling one line as a fixed number of beats.
module l2_cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  address_i,
  input  logic                         read_i,
  input  logic                         write_i,
  input  logic [(2**s_offset)*8-1:0]   line_i,
  output logic [(2**s_offset)*8-1:0]   line_o,
  output logic                         resp_o,
  output logic [31:0]                  address_o,
  output logic                         read_o,
  output logic                         write_o,
  output logic [s_burst-1:0]           burst_o,
  input  logic [s_burst-1:0]           burst_i,
  input  logic                         resp_i
);

  localparam int LINE_W = (2**s_offset) * 8;
  localparam int BEATS  = LINE_W / s_burst;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = 32'((2**s_offset) - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] rd_line;

  // The counter is held at the last beat on exit, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_line <= '0;
      rd_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            addr_q  <= address_i & ~ALIGN_MASK;
            wr_line <= line_i;
            cnt     <= '0;
            state   <= WR_BURST;
          end else if (read_i) begin
            addr_q <= address_i & ~ALIGN_MASK;
            cnt    <= '0;
            state  <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            rd_line[s_burst*int'(cnt) +: s_burst] <= burst_i;
            if (cnt == LAST_BEAT) state <= RD_DONE;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) state <= WR_DONE;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        RD_DONE: state <= IDLE;
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign resp_o    = (state == RD_DONE) || (state == WR_DONE);
  assign address_o = (read_o || write_o) ? addr_q : '0;
  assign burst_o   = write_o ? wr_line[s_burst*int'(cnt) +: s_burst] : '0;
  assign line_o    = rd_line;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: fill, writeback, gaps, priority,
// ignored inputs and asynchronous reset abort.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i, line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o, burst_i;
  logic         resp_i;

  int errors = 0;
  int checks = 0;

  l2_cacheline_adaptor #(.s_offset(5), .s_burst(64)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; address_i = 32'hFFFF_FFFF; read_i = 1'b0; write_i = 1'b0;
    line_i = '1; burst_i = '1; resp_i = 1'b0;
    step(); step();
    checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: rd=%b wr=%b resp=%b, want 0 0 0", read_o, write_o, resp_o);
    end
    checks++;
    if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
      errors++; $display("FAIL reset_data: addr=%h burst=%h line=%h, want all 0", address_o, burst_o, line_o);
    end
    #3 rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}}; beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    address_i = 32'h0000_1234; read_i = 1'b1;
    step();
    read_i = 1'b0; address_i = 32'hDEAD_BEEF;
    checks++;
    if (read_o !== 1'b1 || address_o !== 32'h0000_1220) begin
      errors++; $display("FAIL fill_start: rd=%b addr=%h, want 1 00001220", read_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      burst_i = beats[k]; resp_i = 1'b1;
      step();
      if (k < 3) begin
        checks++;
        if (read_o !== 1'b1 || resp_o !== 1'b0) begin
          errors++; $display("FAIL fill_beat%0d: rd=%b resp=%b, want 1 0", k, read_o, resp_o);
        end
      end
    end
    resp_i = 1'b0; burst_i = '0;
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b1 || address_o !== 32'h0) begin
      errors++; $display("FAIL fill_done: rd=%b resp=%b addr=%h, want 0 1 0", read_o, resp_o, address_o);
    end
    checks++;
    if (line_o !== exp_line) begin
      errors++; $display("FAIL fill_line: got %h want %h", line_o, exp_line);
    end
    step();
    checks++;
    if (resp_o !== 1'b0 || line_o !== exp_line) begin
      errors++; $display("FAIL fill_hold: resp=%b line=%h, want 0 %h", resp_o, line_o, exp_line);
    end
  endtask

  task automatic test_writeback();
    logic [63:0]  d [4];
    logic [255:0] prev_line;
    d[0] = 64'h0123_4567_89AB_CDEF; d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'hA5A5_5A5A_0F0F_F0F0; d[3] = 64'h1357_9BDF_2468_ACE0;
    prev_line = line_o;
    address_i = 32'hABCD_EF40; line_i = {d[3], d[2], d[1], d[0]}; write_i = 1'b1;
    step();
    write_i = 1'b0; line_i = '0; address_i = '0;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'hABCD_EF40) begin
      errors++; $display("FAIL wb_start: wr=%b rd=%b addr=%h, want 1 0 abcdef40", write_o, read_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (burst_o !== d[k]) begin
        errors++; $display("FAIL wb_beat%0d: got %h want %h", k, burst_o, d[k]);
      end
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    checks++;
    if (write_o !== 1'b0 || resp_o !== 1'b1 || burst_o !== 64'h0 || address_o !== 32'h0) begin
      errors++; $display("FAIL wb_done: wr=%b resp=%b burst=%h addr=%h, want 0 1 0 0", write_o, resp_o, burst_o, address_o);
    end
    checks++;
    if (line_o !== prev_line) begin
      errors++; $display("FAIL wb_line_kept: got %h want %h", line_o, prev_line);
    end
    step();
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL wb_resp_once: resp=%b want 0", resp_o);
    end
  endtask

  task automatic test_gapped();
    logic         pat [7];
    logic [63:0]  v [4];
    logic [255:0] exp_line;
    int           n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v[0] = 64'hAAAA_0000_0000_0001; v[1] = 64'hBBBB_0000_0000_0002;
    v[2] = 64'hCCCC_0000_0000_0003; v[3] = 64'hDDDD_0000_0000_0004;
    exp_line = {v[3], v[2], v[1], v[0]};
    address_i = 32'h0000_0047; read_i = 1'b1;
    step();
    read_i = 1'b0;
    checks++;
    if (address_o !== 32'h0000_0040) begin
      errors++; $display("FAIL gap_addr: got %h want 00000040", address_o);
    end
    n = 0;
    for (int c = 0; c < 7; c++) begin
      resp_i = pat[c];
      burst_i = pat[c] ? v[n] : 64'hDEAD_DEAD_DEAD_DEAD;
      if (pat[c]) n++;
      step();
      if (c < 6) begin
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b1) begin
          errors++; $display("FAIL gap_cycle%0d: resp=%b rd=%b, want 0 1", c, resp_o, read_o);
        end
      end
    end
    resp_i = 1'b0;
    checks++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      errors++; $display("FAIL gap_done: resp=%b line=%h, want 1 %h", resp_o, line_o, exp_line);
    end
    step();
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL gap_resp_once: resp=%b want 0", resp_o);
    end
  endtask

  task automatic test_simultaneous();
    address_i = 32'h0000_0300; line_i = {4{64'h5555_6666_7777_8888}};
    read_i = 1'b1; write_i = 1'b1;
    step();
    read_i = 1'b0; write_i = 1'b0;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0) begin
      errors++; $display("FAIL both_priority: wr=%b rd=%b, want 1 0", write_o, read_o);
    end
    resp_i = 1'b1;
    repeat (4) step();
    resp_i = 1'b0;
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL both_done: resp=%b wr=%b, want 1 0", resp_o, write_o);
    end
    step();
  endtask

  task automatic test_ignore();
    // resp_i in IDLE must do nothing.
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); step();
    checks++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      errors++; $display("FAIL idle_resp: resp=%b rd=%b wr=%b, want 0 0 0", resp_o, read_o, write_o);
    end
    // Run a fill; requests raised during the DONE cycle must be ignored.
    resp_i = 1'b0; address_i = 32'h0000_0080; read_i = 1'b1;
    step();
    read_i = 1'b0; resp_i = 1'b1;
    repeat (4) step();
    read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    step();
    read_i = 1'b0; write_i = 1'b0;
    checks++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      errors++; $display("FAIL done_ignore: resp=%b rd=%b wr=%b, want 0 0 0", resp_o, read_o, write_o);
    end
    step();
    resp_i = 1'b0;
    checks++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      errors++; $display("FAIL idle_stay: resp=%b rd=%b wr=%b, want 0 0 0", resp_o, read_o, write_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] exp_line;
    address_i = 32'h0000_0100; read_i = 1'b1;
    step();
    read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
    step(); step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (read_o !== 1'b0 || address_o !== 32'h0 || resp_o !== 1'b0 || line_o !== 256'h0) begin
      errors++; $display("FAIL rst_async: rd=%b addr=%h resp=%b line=%h, want all 0", read_o, address_o, resp_o, line_o);
    end
    resp_i = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    step();
    checks++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      errors++; $display("FAIL rst_no_resp: resp=%b rd=%b, want 0 0", resp_o, read_o);
    end
    exp_line = {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001};
    address_i = 32'h0000_2000; read_i = 1'b1;
    step();
    read_i = 1'b0;
    checks++;
    if (read_o !== 1'b1 || address_o !== 32'h0000_2000) begin
      errors++; $display("FAIL rst_refill_start: rd=%b addr=%h, want 1 00002000", read_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1; burst_i = exp_line[64*k +: 64];
      step();
    end
    resp_i = 1'b0;
    checks++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      errors++; $display("FAIL rst_refill_done: resp=%b line=%h, want 1 %h", resp_o, line_o, exp_line);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_gapped();
    test_simultaneous();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
